// File: rtl/calc_mul_sequencer.sv
// Sign-magnitude 4x4 multiply sequencer: shift-add product, double-dabble BCD,
// then six display digit codes (d1 leftmost) with a one-cycle done pulse.
module calc_mul_sequencer #(
   parameter logic [3:0] BLANK     = 4'hF,
   parameter logic [3:0] MINUS     = 4'hA,
   parameter int         MUL_STEPS = 4,
   parameter int         BCD_STEPS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       clear,
   input  logic       signX,
   input  logic       signY,
   input  logic [3:0] operandX,
   input  logic [3:0] operandY,
   output logic       busy,
   output logic       done,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic [3:0] d4,
   output logic [3:0] d5,
   output logic [3:0] d6
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_BCD  = 3'd2,
      S_FMT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [3:0]  MUL_LAST   = 4'(MUL_STEPS - 1);
   localparam logic [3:0]  BCD_LAST   = 4'(BCD_STEPS - 1);
   localparam logic [23:0] RESET_DISP = {BLANK, BLANK, BLANK, BLANK, BLANK, 4'h0};

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  mcand_q, mcand_d;
   logic [3:0]  mplier_q, mplier_d;
   logic [7:0]  acc_q, acc_d;
   logic [11:0] bcd_q, bcd_d;
   logic        sgn_q, sgn_d;
   logic [23:0] stage_q, stage_d;
   logic [23:0] disp_q, disp_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [11:0] bcd_adj;
   logic [23:0] fmt_codes;

   // Double-dabble correction applied before each shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      fmt_codes = {BLANK, BLANK, BLANK, BLANK, BLANK, bcd_q[3:0]};
      if (sgn_q && (bcd_q != 12'd0))     fmt_codes[23:20] = MINUS;
      if (bcd_q[11:8] != 4'd0)           fmt_codes[11:8]  = bcd_q[11:8];
      if (bcd_q[11:4] != 8'd0)           fmt_codes[7:4]   = bcd_q[7:4];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      bcd_d    = bcd_q;
      sgn_d    = sgn_q;
      stage_d  = stage_q;
      disp_d   = disp_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               mcand_d  = {4'd0, operandX};
               mplier_d = operandY;
               sgn_d    = signX ^ signY;
               acc_d    = 8'd0;
               bcd_d    = 12'd0;
               cnt_d    = 4'd0;
               state_d  = S_MUL;
            end else if (clear) begin
               disp_d  = RESET_DISP;
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            busy_d = 1'b1;
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == MUL_LAST) begin
               cnt_d   = 4'd0;
               state_d = S_BCD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_BCD: begin
            busy_d = 1'b1;
            bcd_d  = {bcd_adj[10:0], acc_q[7]};
            acc_d  = acc_q << 1;
            if (cnt_q == BCD_LAST) begin
               cnt_d   = 4'd0;
               state_d = S_FMT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_FMT: begin
            // First cycle stages the codes, second presents them.
            if (cnt_q == 4'd0) begin
               busy_d  = 1'b1;
               stage_d = fmt_codes;
               cnt_d   = 4'd1;
            end else begin
               disp_d  = stage_q;
               done_d  = 1'b1;
               cnt_d   = 4'd0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         mcand_q  <= 8'd0;
         mplier_q <= 4'd0;
         acc_q    <= 8'd0;
         bcd_q    <= 12'd0;
         sgn_q    <= 1'b0;
         stage_q  <= RESET_DISP;
         disp_q   <= RESET_DISP;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         bcd_q    <= bcd_d;
         sgn_q    <= sgn_d;
         stage_q  <= stage_d;
         disp_q   <= disp_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign {d1, d2, d3, d4, d5, d6} = disp_q;

endmodule

// File: tb/tb_calc_mul_sequencer.sv
// Randomized bench for calc_mul_sequencer against a cycle-timeline reference model.
module tb_calc_mul_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start = 1'b0, clear = 1'b0, signX = 1'b0, signY = 1'b0;
   logic [3:0] operandX = 4'd0, operandY = 4'd0;
   logic       busy, done;
   logic [3:0] d1, d2, d3, d4, d5, d6;

   int checks = 0, failures = 0;
   bit cmp_en = 1'b0;

   localparam logic [23:0] RST_DISP = 24'hFFFFF0;

   calc_mul_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .signX(signX), .signY(signY), .operandX(operandX), .operandY(operandY),
      .busy(busy), .done(done),
      .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] fmt(input bit neg, input int p);
      int h, t, o;
      logic [23:0] r;
      h = p / 100; t = (p / 10) % 10; o = p % 10;
      r = 24'hFFFFFF;
      if (neg && p != 0) r[23:20] = 4'hA;
      if (h != 0) r[11:8] = 4'(h);
      if (h != 0 || t != 0) r[7:4] = 4'(t);
      r[3:0] = 4'(o);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: result appears 14 edges after the accepting edge.
   bit          m_active = 1'b0;
   int          m_k = 0;
   logic [23:0] m_pend = RST_DISP;
   logic [23:0] m_disp = RST_DISP;
   bit          m_busy = 1'b0, m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0; m_k = 0; m_disp = RST_DISP; m_busy = 1'b0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_active) begin
            m_k++;
            m_busy = (m_k <= 13);
            if (m_k == 14) begin
               m_disp = m_pend; m_done = 1'b1; m_active = 1'b0;
            end
         end else begin
            m_busy = 1'b0;
            if (start) begin
               m_pend   = fmt(signX ^ signY, int'(operandX) * int'(operandY));
               m_active = 1'b1;
               m_k      = 0;
            end else if (clear) begin
               m_disp = RST_DISP;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("disp", 32'({d1, d2, d3, d4, d5, d6}), 32'(m_disp));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go(input bit sx, input bit sy, input logic [3:0] x, input logic [3:0] y);
      signX = sx; signY = sy; operandX = x; operandY = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      operandX = 4'($urandom); operandY = 4'($urandom);
      signX = 1'($urandom); signY = 1'($urandom);
   endtask

   task automatic wait_done(input string name, input logic [23:0] exp);
      int lat;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      chk({name, "_latency"}, 32'(lat), 32'd13);
      chk({name, "_digits"}, 32'({d1, d2, d3, d4, d5, d6}), 32'(exp));
   endtask

   initial begin
      // Pin the model's formatting with hand-computed codes.
      chk("fmt_225neg", 32'(fmt(1'b1, 225)), 32'hAFF225);
      chk("fmt_12",     32'(fmt(1'b0, 12)),  32'hFFFFF2 & 32'hFFFF12 | 32'h000010);
      chk("fmt_100",    32'(fmt(1'b0, 100)), 32'hFFF100);
      chk("fmt_neg0",   32'(fmt(1'b1, 0)),   32'hFFFFF0);

      rst_n = 1'b0;
      cyc(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_disp", 32'({d1, d2, d3, d4, d5, d6}), 32'(RST_DISP));
      rst_n = 1'b1;
      cmp_en = 1'b1;
      cyc(2);

      go(1'b0, 1'b1, 4'd15, 4'd15); wait_done("m15x15n", 24'hAFF225);
      cyc(2);
      go(1'b0, 1'b0, 4'd3, 4'd4);   wait_done("m3x4",    24'hFFFF12);
      go(1'b0, 1'b0, 4'd10, 4'd10); wait_done("m10x10",  24'hFFF100);
      go(1'b1, 1'b0, 4'd0, 4'd7);   wait_done("mneg0",   24'hFFFFF0);
      go(1'b1, 1'b1, 4'd9, 4'd1);   wait_done("m9x1",    24'hFFFFF9);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);

      // start and clear while busy are both ignored
      go(1'b0, 1'b0, 4'd15, 4'd15);
      cyc(4);
      operandX = 4'd1; operandY = 4'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc(1);
      clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      chk("busy_ignore", 32'({d1, d2, d3, d4, d5, d6}), 32'hFFF225);

      // asynchronous reset mid-operation
      cyc(2);
      go(1'b1, 1'b0, 4'd13, 4'd11);
      cyc(5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_disp", 32'({d1, d2, d3, d4, d5, d6}), 32'(RST_DISP));
      @(negedge clk); rst_n = 1'b1;
      cyc(1);
      go(1'b0, 1'b0, 4'd2, 4'd3); wait_done("m2x3", 24'hFFFFF6);

      // clear from DONE, then back-to-back start from DONE
      cyc(1);
      clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      chk("clear_disp", 32'({d1, d2, d3, d4, d5, d6}), 32'(RST_DISP));
      go(1'b1, 1'b0, 4'd8, 4'd7); wait_done("m8x7n", 24'hAFFF56);
      go(1'b0, 1'b0, 4'd5, 4'd5); wait_done("b2b",   24'hFFFF25);
      go(1'b0, 1'b1, 4'd12, 4'd9); wait_done("m12x9n", 24'hAFF108);

      // randomized traffic; the compare process checks every cycle
      for (int i = 0; i < 1500; i++) begin
         start    = ($urandom_range(0, 7) == 0);
         clear    = ($urandom_range(0, 5) == 0);
         signX    = 1'($urandom); signY = 1'($urandom);
         operandX = 4'($urandom); operandY = 4'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      start = 1'b0; clear = 1'b0;
      cyc(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
